// File: rtl/imem_loader_if.sv
// Byte-stream handshake that carries a program image into the instruction loader.
// A byte moves on a clock edge where rx_valid and rx_ready are both high.
interface imem_loader_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;

    modport master (
        output rx_valid,
        output rx_data,
        input  rx_ready
    );

    modport slave (
        input  rx_valid,
        input  rx_data,
        output rx_ready
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses COUNT / data words / CHECK from a byte stream,
// fills the instruction RAM, serves fetch reads and holds the core until a good load.
module imem_loader #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int IW    = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_start,
    imem_loader_if.slave  rx,
    input  logic [AW-1:0] fetch_addr,
    output logic [IW-1:0] fetch_data,
    output logic          core_hold,
    output logic          load_done,
    output logic          load_err,
    output logic [AW:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_HI,
        S_LO,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t        state;
    state_t        state_n;

    logic [IW-1:0] mem [DEPTH];
    logic [AW:0]   n_reg;
    logic [AW-1:0] wr_ptr;
    logic [7:0]    csum;
    logic [7:0]    hi_reg;

    logic          rx_ready;
    logic          xfer;
    logic          count_bad;
    logic          last_word;

    assign rx.rx_ready = rx_ready;
    assign xfer        = rx.rx_valid & rx_ready;
    assign count_bad   = (rx.rx_data == 8'd0) || (rx.rx_data > 8'(DEPTH));
    assign last_word   = ({1'b0, wr_ptr} == (n_reg - 1'b1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        rx_ready = 1'b0;

        case (state)
            S_COUNT, S_HI, S_LO, S_CHECK, S_ERROR: rx_ready = 1'b1;
            default:                               rx_ready = 1'b0;
        endcase

        // A restart pulse must not swallow a byte offered in the same cycle.
        if (load_start) begin
            rx_ready = 1'b0;
        end

        case (state)
            S_COUNT: begin
                if (xfer) begin
                    state_n = count_bad ? S_ERROR : S_HI;
                end
            end
            S_HI: begin
                if (xfer) begin
                    state_n = S_LO;
                end
            end
            S_LO: begin
                if (xfer) begin
                    state_n = last_word ? S_CHECK : S_HI;
                end
            end
            S_CHECK: begin
                if (xfer) begin
                    state_n = (rx.rx_data == csum) ? S_DONE : S_ERROR;
                end
            end
            default: begin
                state_n = state;
            end
        endcase

        if (load_start) begin
            state_n = S_COUNT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            n_reg        <= '0;
            wr_ptr       <= '0;
            csum         <= '0;
            hi_reg       <= '0;
            words_loaded <= '0;
        end else if (xfer) begin
            case (state)
                S_COUNT: begin
                    if (!count_bad) begin
                        n_reg        <= rx.rx_data[AW:0];
                        csum         <= rx.rx_data;
                        wr_ptr       <= '0;
                        words_loaded <= '0;
                    end
                end
                S_HI: begin
                    hi_reg <= rx.rx_data;
                    csum   <= csum ^ rx.rx_data;
                end
                S_LO: begin
                    mem[wr_ptr]  <= {hi_reg, rx.rx_data};
                    csum         <= csum ^ rx.rx_data;
                    wr_ptr       <= wr_ptr + 1'b1;
                    words_loaded <= words_loaded + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Status flags are pure functions of the state so they track every transition exactly.
    assign core_hold = (state != S_DONE);
    assign load_done = (state == S_DONE);
    assign load_err  = (state == S_ERROR);

    always_comb begin
        fetch_data = '0;
        if ({1'b0, fetch_addr} < (AW+1)'(DEPTH)) begin
            fetch_data = mem[fetch_addr];
        end
    end

endmodule
